// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmitter framing words from an FWFT FIFO; optional line break via macro UART_TX_BREAK_EN
module uart_tx_framer #(
  parameter int DataLength = 8,
  parameter int OverSample = 8,
  parameter int ParityMode = 0,
  parameter int StopBits   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic                  i_break,
`endif
  output logic                  o_tx,
  input  logic [DataLength-1:0] i_tx_fifo_data,
  input  logic                  i_tx_fifo_empty,
  output logic                  o_tx_fifo_read_en,
  output logic                  o_busy
);
  localparam int CW = $clog2(OverSample);
  localparam int BW = $clog2(DataLength + 1);
  localparam logic [CW-1:0] CntLoad = CW'(OverSample - 1);
  localparam logic [BW-1:0] LastData = BW'(DataLength - 1);
  localparam logic [BW-1:0] LastStop = BW'(StopBits - 1);
`ifdef UART_TX_BREAK_EN
  localparam int FrameLen = OverSample * (1 + DataLength + (ParityMode != 0 ? 1 : 0) + StopBits);
  localparam int KW = $clog2(FrameLen);
  localparam logic [KW-1:0] BrkLoad = KW'(FrameLen - 1);
`endif

  if (DataLength < 5 || DataLength > 9 || OverSample < 2 || ParityMode < 0 || ParityMode > 2 ||
      StopBits < 1 || StopBits > 2) begin : g_param_check
    $error("uart_tx_framer: parameter outside legal range");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
    , BREAK
`endif
  } state_t;

  state_t                state_q, state_d;
  logic                  tx_q, tx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DataLength-1:0] sh_q, sh_d;
  logic                  par_q, par_d;
  logic                  cap;
  logic                  bit_end;
`ifdef UART_TX_BREAK_EN
  logic [KW-1:0]         brk_q, brk_d;
`endif

  assign bit_end           = cnt_q == '0;
  assign o_tx              = tx_q;
  assign o_busy            = state_q != IDLE;
  assign o_tx_fifo_read_en = cap & i_rst_n;

  // next state, next line level and bit timing; a capture (from IDLE or a frame end) overrides the rest
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    cnt_d   = bit_end ? CntLoad : cnt_q - 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    cap     = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_d   = brk_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = CntLoad;
`ifdef UART_TX_BREAK_EN
        if (i_break) begin
          state_d = BREAK;
          tx_d    = 1'b0;
          brk_d   = BrkLoad;
        end else
`endif
        cap = !i_tx_fifo_empty;
      end
      START: if (bit_end) begin
        state_d = DATA;
        tx_d    = sh_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == LastData) begin
          bit_d   = '0;
          state_d = ParityMode != 0 ? PARITY : STOP;
          tx_d    = ParityMode != 0 ? par_q : 1'b1;
        end else begin
          bit_d = bit_q + 1'b1;
          sh_d  = sh_q >> 1;
          tx_d  = sh_q[1];
        end
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: if (bit_end) begin
        if (bit_q == LastStop) begin
          bit_d = '0;
`ifdef UART_TX_BREAK_EN
          if (i_break) begin
            state_d = BREAK;
            tx_d    = 1'b0;
            brk_d   = BrkLoad;
          end else
`endif
          begin
            state_d = IDLE;
            tx_d    = 1'b1;
            cap     = !i_tx_fifo_empty;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        brk_d = brk_q == '0 ? brk_q : brk_q - 1'b1;
        if (brk_q == '0 && !i_break) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (cap) begin
      state_d = START;
      tx_d    = 1'b0;
      cnt_d   = CntLoad;
      sh_d    = i_tx_fifo_data;
      par_d   = ^i_tx_fifo_data ^ (ParityMode == 2);
    end
  end

  // state and datapath registers, forced to idle immediately on reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= CntLoad;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q   <= BrkLoad;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
`ifdef UART_TX_BREAK_EN
      brk_q   <= brk_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: scoreboard bench over three framer configurations
module tb_uart_tx_framer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [2:0] done = '0;

  typedef struct packed {
    logic        brk;
    logic [15:0] bits;
  } exp_t;

  task automatic chk(input int g, input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL u%0d %s: got %0h want %0h", g, n, a, e);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int DL = g == 0 ? 8 : g == 1 ? 9 : 7;
    localparam int OS = g == 2 ? 3 : 8;
    localparam int PM = g;
    localparam int SB = g == 1 ? 2 : 1;
    localparam int NB = 1 + DL + (PM != 0 ? 1 : 0) + SB;

    logic          rst_n = 1'b0;
    logic          tx, rd, busy;
    logic          empty = 1'b1;
    logic          brk_v = 1'b0;
    logic [DL-1:0] data = '0;
    logic [DL-1:0] fifo [$];
    exp_t          expq [$];
    logic          rd_s;
    bit            mon_in;
    int            mon_k;
    int            pushes = 0;
    int            pops = 0;

    uart_tx_framer #(.DataLength(DL), .OverSample(OS), .ParityMode(PM), .StopBits(SB)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
      .i_break(brk_v),
`endif
      .o_tx(tx),
      .i_tx_fifo_data(data),
      .i_tx_fifo_empty(empty),
      .o_tx_fifo_read_en(rd),
      .o_busy(busy)
    );

    function automatic logic [15:0] frame(input logic [DL-1:0] w);
      logic [15:0] f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < DL; i++) f[1+i] = w[i];
      if (PM != 0) f[1+DL] = (($countones(w) % 2) == 1) ^ (PM == 2);
      return f;
    endfunction

    task automatic drive();
      empty = fifo.size() == 0;
      data  = empty ? DL'($urandom) : fifo[0];
    endtask

    task automatic push(input logic [DL-1:0] w);
      fifo.push_back(w);
      expq.push_back('{brk: 1'b0, bits: frame(w)});
      pushes++;
      drive();
    endtask

    task automatic tick();
      @(negedge clk);
      rd_s = rd;
      @(posedge clk);
      #1;
      if (rd_s === 1'b1 && fifo.size() != 0) begin
        void'(fifo.pop_front());
        pops++;
      end
      drive();
    endtask

    task automatic wait_idle(input int maxc);
      bit ok = 1'b0;
      for (int c = 0; c < maxc && !ok; c++) begin
        tick();
        ok = fifo.size() == 0 && busy === 1'b0 && !mon_in;
      end
      chk(g, "idle_reached", ok, 1);
    endtask

    initial begin
      exp_t cur = '0;
      logic prd = 1'b0;
      mon_in = 1'b0;
      mon_k  = 0;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          mon_in = 1'b0;
          prd    = 1'b0;
        end else begin
          if (!mon_in && (tx === 1'b0 || prd === 1'b1)) begin
            chk(g, "exp_pending", expq.size() != 0, 1);
            if (expq.size() != 0) begin
              cur = expq.pop_front();
              chk(g, "pop_then_start", prd, !cur.brk);
              mon_in = 1'b1;
              mon_k  = 0;
            end
          end
          if (mon_in) begin
            chk(g, "tx", tx, cur.brk ? 1'b0 : cur.bits[mon_k/OS]);
            chk(g, "busy", busy, 1);
            chk(g, "rd", rd, mon_k == NB*OS-1 && !cur.brk && !empty);
            mon_k++;
            if (mon_k == NB*OS) mon_in = 1'b0;
          end else begin
            chk(g, "idle_tx", tx, 1);
            chk(g, "idle_busy", busy, 0);
            chk(g, "idle_rd", rd, !empty && !brk_v);
          end
          prd = rd;
        end
      end
    end

    initial begin
      bit ok;
      int gap;
      push(DL'(g == 0 ? 32'hA5 : g == 1 ? 32'h1FF : 32'h07));
      if (g == 1) begin
        push(DL'(32'h07));
        push(DL'($urandom));
      end
      repeat (3) @(negedge clk);
      chk(g, "rst_tx", tx, 1);
      chk(g, "rst_busy", busy, 0);
      chk(g, "rst_rd", rd, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_idle(2000);
      if (g == 0) begin
        push(DL'($urandom));
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
          tick();
          ok = mon_in && mon_k >= OS*4+2;
        end
        chk(g, "reached_bit3", ok, 1);
        #2 rst_n = 1'b0;
        #1;
        chk(g, "arst_tx", tx, 1);
        chk(g, "arst_busy", busy, 0);
        chk(g, "arst_rd", rd, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        push(DL'($urandom));
        wait_idle(2000);
`ifdef UART_TX_BREAK_EN
        repeat (5) tick();
        brk_v = 1'b1;
        expq.push_back('{brk: 1'b1, bits: 16'h0});
        tick();
        brk_v = 1'b0;
        wait_idle(500);
        brk_v = 1'b1;
        expq.push_back('{brk: 1'b1, bits: 16'h0});
        push(DL'($urandom));
        tick();
        brk_v = 1'b0;
        wait_idle(500);
`endif
      end
      for (int n = 0; n < 20; n++) begin
        gap = $urandom_range(0, 3) == 0 ? $urandom_range(0, 150) : 0;
        repeat (gap) tick();
        push(DL'($urandom));
        if ($urandom_range(0, 1) == 0) tick();
      end
      wait_idle(8000);
      chk(g, "pop_count", pops, pushes);
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 60000 && done != 3'b111; c++) @(posedge clk);
    chk(0, "all_done", done, 3'b111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DataLength, default 8: data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter OverSample, default 8: i_clk cycles per bit; legal range >=2.
REQ-003 SHALL have parameter ParityMode, default 0: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter StopBits, default 1: stop bits per frame; legal 1 or 2.
REQ-005 SHALL have port i_clk  input  1: clock at baud rate * OverSample.
REQ-006 SHALL have port i_rst_n  input  1: reset, asynchronous, active-low.
REQ-007 SHALL have port o_tx  output  1: serial line, idle high.
REQ-008 SHALL have port i_tx_fifo_data  input  DataLength: first-word-fall-through FIFO head word.
REQ-009 SHALL have port i_tx_fifo_empty  input  1: FIFO empty flag.
REQ-010 SHALL have port o_tx_fifo_read_en  output  1: single-cycle pop strobe.
REQ-011 SHALL have port o_busy  output  1: high while a frame or break is in progress.
REQ-012 SHALL raise an elaboration error for any parameter outside its legal range.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be unreachable when ParityMode=0.
REQ-014 SHALL, in IDLE with i_tx_fifo_empty=0, latch i_tx_fifo_data into an internal shift register, assert o_tx_fifo_read_en for exactly that cycle, and enter START on the next edge.
REQ-015 SHALL drive o_tx from a flop updated on the same edge the FSM enters each state; the start bit begins on the edge after the capture cycle.
REQ-016 SHALL hold each bit (start, data, parity, stop) on o_tx for exactly OverSample cycles, timed by a down-counter reloaded to OverSample-1 at each bit boundary.
REQ-017 SHALL transmit the data bits LSB first from the latched copy; later FIFO head changes SHALL NOT affect the frame in flight.
REQ-018 SHALL compute parity over the latched word: even drives XOR of the bits, odd drives its inverse.
REQ-019 SHALL transmit StopBits stop bits high; frame length SHALL be OverSample*(1+DataLength+(ParityMode!=0)+StopBits) cycles.
REQ-020 SHALL size the bit counter to $clog2(DataLength+1) so DataLength=8 and 9 never wrap early.
REQ-021 SHALL, in the last cycle of the last stop bit with FIFO non-empty, capture and pop (per REQ-014) and enter START directly, with zero idle cycles between frames.
REQ-022 SHALL return to IDLE after the last stop bit when the FIFO is empty, with o_tx held high.
REQ-023 SHALL NOT assert o_tx_fifo_read_en while i_tx_fifo_empty=1 or outside a capture cycle.
REQ-024 SHALL drive o_busy high from START entry through the final stop-bit cycle, and low in IDLE.

Reset
REQ-025 SHALL on i_rst_n low immediately force state IDLE, o_tx=1, o_tx_fifo_read_en=0, o_busy=0, and counters to their reload values.
REQ-026 SHALL abandon a frame interrupted by reset mid-transmission without resuming it; the popped word is lost.
REQ-027 SHALL capture no word before the first rising edge after i_rst_n deasserts.

Configuration
REQ-028 SHALL, with macro UART_TX_BREAK_EN defined, add port i_break  input  1 and state BREAK.
REQ-029 SHALL, with UART_TX_BREAK_EN defined, enter BREAK from IDLE or from a frame end when i_break=1; break SHALL take priority over pending FIFO data.
REQ-030 SHALL, in BREAK, drive o_tx=0 and o_busy=1 with no FIFO pops, for at least one full frame length and until i_break=0, then return to IDLE.
REQ-031 SHALL, without UART_TX_BREAK_EN, omit the i_break port and the BREAK state entirely.

Verification
REQ-032 SHALL verify: defaults, one word 0xA5 -> o_tx pattern 0,1,0,1,0,0,1,0,1,1 with 8 cycles per bit; one read_en pulse; o_busy 80 cycles.
REQ-033 SHALL verify: ParityMode=1 and ParityMode=2, word 0x07 -> parity bit 1 (even) and 0 (odd).
REQ-034 SHALL verify: StopBits=2, three words queued -> frames back-to-back with 16 high cycles between data and the next start bit, three pops.
REQ-035 SHALL verify: i_rst_n low during data bit 3 -> o_tx=1 and o_busy=0 immediately, no pop until the FIFO is next non-empty.
REQ-036 SHALL verify: DataLength=9, word 0x1FF -> nine 1 bits; FIFO head changed mid-frame -> frame unchanged.
REQ-037 SHALL verify: with UART_TX_BREAK_EN, i_break pulsed for 1 cycle in IDLE -> o_tx low for exactly one frame length (80 cycles at defaults), with no pop.
